// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the HPS status-word field layout.
// The bit offsets are shared with the HPS driver header.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned USER_W     = 22;
  localparam int unsigned X_LSB      = 0;
  localparam int unsigned Y_LSB      = 10;
  localparam int unsigned ODD_BIT    = 20;
  localparam int unsigned VBLANK_BIT = 21;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis; exposes the next value so the parent can
// register decodes that line up with the counter itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned TOTAL = 800
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = (cnt_q == Last);
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/vga_timing_status.sv
// VGA raster timing generator with registered sync/blank/coordinate outputs and
// a pixel-rate snapshot of raster state for the HPS PIO.
module vga_timing_status #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  input  logic                              en,
  output logic                              vga_clk,
  output logic                              vga_hs,
  output logic                              vga_vs,
  output logic                              vga_blank_n,
  output logic                              vga_sync_n,
  output logic [CNT_W-1:0]                  pix_x,
  output logic [CNT_W-1:0]                  pix_y,
  output logic                              pix_valid,
  output logic                              frame_start,
  output logic [vga_timing_pkg::USER_W-1:0] vga_user_export
);
  import vga_timing_pkg::*;

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HActEnd  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncBeg = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VActEnd  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSyncBeg = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DivW-1:0]   div_q, div_d;
  logic              pe, clear;
  logic [CNT_W-1:0]  h_cnt, h_next, v_cnt, v_next;
  logic              h_wrap, v_wrap;
  logic              frame_odd_q, frame_odd_d;
  logic              restart_q, restart_d;
  logic              vga_clk_q, vga_clk_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic              blank_n_q, blank_n_d;
  logic              pix_valid_q, pix_valid_d;
  logic              frame_start_q, frame_start_d;
  logic [USER_W-1:0] user_q, user_d;

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .TOTAL (HTotal)
  ) u_h_cnt (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .clear_i    (clear),
    .inc_i      (pe),
    .cnt_o      (h_cnt),
    .cnt_next_o (h_next),
    .wrap_o     (h_wrap)
  );

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .TOTAL (VTotal)
  ) u_v_cnt (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .clear_i    (clear),
    .inc_i      (pe && h_wrap),
    .cnt_o      (v_cnt),
    .cnt_next_o (v_next),
    .wrap_o     (v_wrap)
  );

  always_comb begin
    clear       = !en;
    pe          = en && (div_q == DivLast);
    div_d       = (!en || (div_q == DivLast)) ? '0 : div_q + DivW'(1);
    frame_odd_d = frame_odd_q ^ (pe && h_wrap && v_wrap);
    // A disabled raster parks at the origin; its first pixel counts as a new frame.
    restart_d   = !en ? 1'b1 : (pe ? 1'b0 : restart_q);

    vga_clk_d     = (div_d < DivHalf);
    hs_d          = !(en && (h_next >= HSyncBeg) && (h_next < HSyncEnd));
    vs_d          = !(en && (v_next >= VSyncBeg) && (v_next < VSyncEnd));
    blank_n_d     = en && (h_next < HActEnd) && (v_next < VActEnd);
    pix_valid_d   = pe;
    frame_start_d = pe && (((h_next == '0) && (v_next == '0)) || restart_q);

    user_d = user_q;
    if (!en) begin
      user_d = '0;
    end else if (pe) begin
      user_d[X_LSB +: COORD_W] = COORD_W'(h_next);
      user_d[Y_LSB +: COORD_W] = COORD_W'(v_next);
      user_d[ODD_BIT]          = frame_odd_d;
      user_d[VBLANK_BIT]       = (v_next >= VActEnd);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      div_q         <= '0;
      frame_odd_q   <= 1'b0;
      restart_q     <= 1'b0;
      vga_clk_q     <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      user_q        <= '0;
    end else begin
      div_q         <= div_d;
      frame_odd_q   <= frame_odd_d;
      restart_q     <= restart_d;
      vga_clk_q     <= vga_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      user_q        <= user_d;
    end
  end

  assign vga_clk         = vga_clk_q;
  assign vga_hs          = hs_q;
  assign vga_vs          = vs_q;
  assign vga_blank_n     = blank_n_q;
  assign vga_sync_n      = 1'b0;
  assign pix_x           = h_cnt;
  assign pix_y           = v_cnt;
  assign pix_valid       = pix_valid_q;
  assign frame_start     = frame_start_q;
  assign vga_user_export = user_q;

endmodule

// File: tb/tb_vga_timing_status.sv
// Bench: full-size 640x480 instance plus a tiny-raster CLK_DIV=4 instance, each
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_status;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, en_a, rst_n_b, en_b;
  logic vga_clk_a, hs_a, vs_a, blank_a, sync_a, pv_a, fs_a;
  logic vga_clk_b, hs_b, vs_b, blank_b, sync_b, pv_b, fs_b;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic [21:0] user_a, user_b;

  vga_timing_status u_dut_a (
    .clk_clk (clk), .reset_reset_n (rst_n_a), .en (en_a),
    .vga_clk (vga_clk_a), .vga_hs (hs_a), .vga_vs (vs_a), .vga_blank_n (blank_a),
    .vga_sync_n (sync_a), .pix_x (x_a), .pix_y (y_a), .pix_valid (pv_a),
    .frame_start (fs_a), .vga_user_export (user_a)
  );

  vga_timing_status #(
    .CLK_DIV (4), .H_ACTIVE (6), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) u_dut_b (
    .clk_clk (clk), .reset_reset_n (rst_n_b), .en (en_b),
    .vga_clk (vga_clk_b), .vga_hs (hs_b), .vga_vs (vs_b), .vga_blank_n (blank_b),
    .vga_sync_n (sync_b), .pix_x (x_b), .pix_y (y_b), .pix_valid (pv_b),
    .frame_start (fs_b), .vga_user_export (user_b)
  );

  int checks = 0;
  int failures = 0;

  // Model state: cycles since the raster last sat at the origin, frame parity at
  // that moment, and whether the origin was reached by dropping en.
  typedef struct { int cyc; bit ob; bit rs; bit valid; } mstate_t;
  mstate_t ma = '{0, 1'b0, 1'b0, 1'b0};
  mstate_t mb = '{0, 1'b0, 1'b0, 1'b0};
  logic cap_rst_a, cap_en_a, cap_rst_b, cap_en_b;

  always @(posedge clk) begin
    cap_rst_a <= rst_n_a;
    cap_en_a  <= en_a;
    cap_rst_b <= rst_n_b;
    cap_en_b  <= en_b;
  end

  function automatic mstate_t advance(mstate_t m, logic r, logic e, int d, int frame_px);
    mstate_t n = m;
    if (r !== 1'b1) begin
      n.cyc = 0; n.ob = 1'b0; n.rs = 1'b0; n.valid = 1'b1;
    end else if (e !== 1'b1) begin
      n.ob  = m.ob ^ bit'(((m.cyc / d) / frame_px) % 2);
      n.cyc = 0; n.rs = 1'b1;
    end else begin
      n.cyc = m.cyc + 1;
    end
    return n;
  endfunction

  function automatic logic [48:0] expect_out(int d, int ha, int hf, int hs, int hb,
                                             int va, int vf, int vs, int vb,
                                             int cyc, bit ob, bit rs);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int n  = cyc / d;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    bit odd  = ob ^ bit'((n / (ht * vt)) % 2);
    bit idle = (cyc == 0);
    bit pv   = !idle && (cyc % d == 0);
    bit fs   = pv && (((h == 0) && (v == 0)) || (rs && n == 1));
    bit vclk = (cyc % d) < (d / 2);
    bit hs_n = idle || !((h >= ha + hf) && (h < ha + hf + hs));
    bit vs_n = idle || !((v >= va + vf) && (v < va + vf + vs));
    bit bl   = !idle && (h < ha) && (v < va);
    logic [21:0] u = (n == 0) ? 22'd0 : {bit'(v >= va), odd, 10'(v), 10'(h)};
    return {vclk, hs_n, vs_n, bl, 1'b0, 10'(h), 10'(v), pv, fs, u};
  endfunction

  logic [48:0] exp_v, act_v;

  initial forever begin
    @(negedge clk);
    ma = advance(ma, cap_rst_a, cap_en_a, 2, 800 * 525);
    mb = advance(mb, cap_rst_b, cap_en_b, 4, 117);
    if (ma.valid) begin
      exp_v = expect_out(2, 640, 16, 96, 48, 480, 10, 2, 33, ma.cyc, ma.ob, ma.rs);
      act_v = {vga_clk_a, hs_a, vs_a, blank_a, sync_a, x_a, y_a, pv_a, fs_a, user_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_a t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
    if (mb.valid) begin
      exp_v = expect_out(4, 6, 2, 3, 2, 4, 1, 2, 2, mb.cyc, mb.ob, mb.rs);
      act_v = {vga_clk_b, hs_b, vs_b, blank_b, sync_b, x_b, y_b, pv_b, fs_b, user_b};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_b t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
  end

  // Line statistics for A and frame statistics for B while mon_on is set.
  bit mon_on = 1'b0;
  int cyc_cnt = 0;
  bit ln_started = 1'b0;
  int cur_len, cur_hs, cur_bl, hs_first, hs_last, bl_last, line_t0;
  int last_len = -1, last_hs = -1, last_bl = -1, last_hs_first = -1, last_hs_last = -1;
  int last_bl_last = -1, last_clks = -1, lines_done = 0;
  bit pv_seen = 1'b0, fs_seen = 1'b0, prev_odd = 1'b0;
  int last_pv_t, bad_pv = 0, fs_strobes = 0, fs_t0 = 0, fs_n = 0, bad_fs = 0, bad_odd = 0;
  int last_fs_str = -1, last_fs_clks = -1;
  int vs_min = 999, vs_max = -1, vb_min = 999, vb_max = -1;

  initial forever begin
    @(negedge clk);
    cyc_cnt++;
    if (mon_on && pv_a) begin
      if (x_a == 0) begin
        if (ln_started) begin
          last_len = cur_len; last_hs = cur_hs; last_bl = cur_bl;
          last_hs_first = hs_first; last_hs_last = hs_last; last_bl_last = bl_last;
          last_clks = cyc_cnt - line_t0;
          lines_done++;
        end
        ln_started = 1'b1;
        cur_len = 0; cur_hs = 0; cur_bl = 0; hs_first = -1; hs_last = -1; bl_last = -1;
        line_t0 = cyc_cnt;
      end
      if (ln_started) begin
        cur_len++;
        if (!hs_a) begin
          cur_hs++;
          if (hs_first < 0) hs_first = int'(x_a);
          hs_last = int'(x_a);
        end
        if (blank_a) begin
          cur_bl++;
          bl_last = int'(x_a);
        end
      end
    end
    if (mon_on && pv_b) begin
      if (pv_seen && (cyc_cnt - last_pv_t != 4)) bad_pv++;
      pv_seen = 1'b1;
      last_pv_t = cyc_cnt;
      fs_strobes++;
      if (!vs_b) begin
        if (int'(y_b) < vs_min) vs_min = int'(y_b);
        if (int'(y_b) > vs_max) vs_max = int'(y_b);
      end
      if (user_b[21]) begin
        if (int'(y_b) < vb_min) vb_min = int'(y_b);
        if (int'(y_b) > vb_max) vb_max = int'(y_b);
      end
      if (fs_b) begin
        if (fs_seen) begin
          last_fs_str  = fs_strobes;
          last_fs_clks = cyc_cnt - fs_t0;
          if (fs_strobes != 117 || last_fs_clks != 468) bad_fs++;
          if (user_b[20] == prev_odd) bad_odd++;
        end
        fs_seen = 1'b1;
        fs_n++;
        fs_strobes = 0;
        fs_t0 = cyc_cnt;
        prev_odd = user_b[20];
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit found;
  bit odd_before;

  initial begin
    rst_n_a = 1'b0; en_a = 1'b1; rst_n_b = 1'b0; en_b = 1'b1;
    tick(3);
    chk("a_rst_vclk", int'(vga_clk_a), 1);
    chk("a_rst_hs", int'(hs_a), 1);
    chk("a_rst_blank", int'(blank_a), 0);
    chk("a_rst_user", int'(user_a), 0);
    tick(2);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    tick(1);
    chk("a_clk1_pv", int'(pv_a), 0);
    tick(1);
    chk("a_first_pv", int'(pv_a), 1);
    chk("a_first_x", int'(x_a), 1);
    chk("a_first_y", int'(y_a), 0);
    chk("a_first_fs", int'(fs_a), 0);
    chk("b_clk2_pv", int'(pv_b), 0);
    chk("b_clk2_vclk", int'(vga_clk_b), 0);

    mon_on = 1'b1;
    tick(3300);
    mon_on = 1'b0;
    chk("a_lines_seen", int'(lines_done >= 1), 1);
    chk("a_line_strobes", last_len, 800);
    chk("a_line_clks", last_clks, 1600);
    chk("a_hs_strobes", last_hs, 96);
    chk("a_hs_first", last_hs_first, 656);
    chk("a_hs_last", last_hs_last, 751);
    chk("a_blank_strobes", last_bl, 640);
    chk("a_blank_last", last_bl_last, 639);
    chk("b_frames_seen", int'(fs_n >= 3), 1);
    chk("b_frame_strobes", last_fs_str, 117);
    chk("b_frame_clks", last_fs_clks, 468);
    chk("b_bad_frame_iv", bad_fs, 0);
    chk("b_odd_toggle_bad", bad_odd, 0);
    chk("b_pv_period_bad", bad_pv, 0);
    chk("b_vs_min_line", vs_min, 5);
    chk("b_vs_max_line", vs_max, 6);
    chk("b_vblank_min", vb_min, 4);
    chk("b_vblank_max", vb_max, 8);

    // en drop mid-frame on the small raster
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (pv_b && x_b == 10'd3 && y_b == 10'd2) found = 1'b1;
    end
    chk("b_wait_mid", int'(found), 1);
    odd_before = user_b[20];
    en_b = 1'b0;
    tick(10);
    chk("b_hold_x", int'(x_b), 0);
    chk("b_hold_y", int'(y_b), 0);
    chk("b_hold_user", int'(user_b), 0);
    chk("b_hold_blank", int'(blank_b), 0);
    en_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (pv_b) found = 1'b1;
    end
    chk("b_reen_wait", int'(found), 1);
    chk("b_reen_fs", int'(fs_b), 1);
    chk("b_reen_x", int'(x_b), 1);
    chk("b_odd_held", int'(user_b[20]), int'(odd_before));

    // reset landing exactly on the wrap edge
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1);
      if (pv_b && x_b == 10'd12 && y_b == 10'd8) found = 1'b1;
    end
    chk("b_wait_wrap", int'(found), 1);
    tick(3);
    rst_n_b = 1'b0;
    tick(1);
    chk("b_wraprst_fs", int'(fs_b), 0);
    chk("b_wraprst_x", int'(x_b), 0);
    chk("b_wraprst_y", int'(y_b), 0);
    chk("b_wraprst_user", int'(user_b), 0);
    chk("b_wraprst_vclk", int'(vga_clk_b), 1);
    rst_n_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (pv_b) found = 1'b1;
    end
    chk("b_post_rst_wait", int'(found), 1);
    chk("b_post_rst_odd", int'(user_b[20]), 0);

    // random enable drops and resets, model-checked every cycle
    for (int i = 0; i < 6000; i++) begin
      tick(1);
      rst_n_a = ($urandom_range(0, 999) >= 3);
      en_a    = ($urandom_range(0, 99) >= 2);
      rst_n_b = ($urandom_range(0, 999) >= 3);
      en_b    = ($urandom_range(0, 99) >= 2);
    end
    rst_n_a = 1'b1; en_a = 1'b1; rst_n_b = 1'b1; en_b = 1'b1;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
